resp_framer: RTL and testbench

RESP_FRAMER -- requirements
Module: resp_framer

---
 rtl/resp_framer_pkg.sv | 15 +
 rtl/resp_framer.sv | 127 ++++++++++++
 tb/tb_resp_framer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/resp_framer_pkg.sv
// Shared types and constants for the response framer.
package resp_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    B0,
    B1,
    CHK
  } state_t;

  localparam logic [7:0] HDR_ALU = 8'h5A;
  localparam logic [7:0] HDR_RD  = 8'hA5;

endpackage

// File: rtl/resp_framer.sv
// Frames ALU results and register reads into byte streams for an async FIFO,
// with optional header/XOR-checksum wrapping and a one-deep pending read slot.
module resp_framer
  import resp_framer_pkg::*;
#(
  parameter bit FRAME_EN  = 1'b1,
  parameter int ALU_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic [ALU_WIDTH-1:0] ALU_OUT,
  input  logic                 OUT_VALID,
  input  logic [7:0]           Rd_DATA,
  input  logic                 Rd_Valid,
  input  logic                 FIFO_FULL,
  output logic [7:0]           WR_DATA,
  output logic                 WR_INC,
  output logic                 READY,
  output logic                 OVERRUN
);

  localparam state_t START = FRAME_EN ? HDR : B0;

  state_t      state;
  logic [15:0] payload;
  logic        is_alu;
  logic        pend_valid;
  logic [7:0]  pend_data;
  logic [7:0]  chk;
  logic [7:0]  wr_data_q;
  logic        overrun_q;
  logic        last_byte;
  logic        any_valid;

  assign READY   = (state == IDLE) && !pend_valid;
  assign WR_INC  = (state != IDLE) && !FIFO_FULL;
  assign WR_DATA = wr_data_q;
  assign OVERRUN = overrun_q;
  assign any_valid = OUT_VALID || Rd_Valid;

  // The byte being written this cycle is the final one of its frame.
  always_comb begin
    last_byte = 1'b0;
    if (WR_INC) begin
      if (state == CHK)
        last_byte = 1'b1;
      else if (!FRAME_EN && (state == B1 || (state == B0 && !is_alu)))
        last_byte = 1'b1;
    end
  end

  // WR_DATA is loaded together with each state change, so it always
  // matches the byte the state is about to emit.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      payload    <= 16'h0000;
      is_alu     <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= 8'h00;
      chk        <= 8'h00;
      wr_data_q  <= 8'h00;
      overrun_q  <= 1'b0;
    end else begin
      if (any_valid && !READY)
        overrun_q <= 1'b1;

      if (READY && any_valid) begin
        state <= START;
        chk   <= 8'h00;
        if (OUT_VALID) begin
          payload   <= ALU_OUT;
          is_alu    <= 1'b1;
          wr_data_q <= FRAME_EN ? HDR_ALU : ALU_OUT[7:0];
          if (Rd_Valid) begin
            pend_valid <= 1'b1;
            pend_data  <= Rd_DATA;
          end
        end else begin
          payload   <= {8'h00, Rd_DATA};
          is_alu    <= 1'b0;
          wr_data_q <= FRAME_EN ? HDR_RD : Rd_DATA;
        end
      end else if (last_byte) begin
        chk <= 8'h00;
        if (pend_valid) begin
          state      <= START;
          payload    <= {8'h00, pend_data};
          is_alu     <= 1'b0;
          pend_valid <= 1'b0;
          wr_data_q  <= FRAME_EN ? HDR_RD : pend_data;
        end else begin
          state     <= IDLE;
          wr_data_q <= 8'h00;
        end
      end else if (WR_INC) begin
        // Checksum accumulates payload bytes only, never the header.
        case (state)
          HDR: begin
            state     <= B0;
            wr_data_q <= payload[7:0];
          end
          B0: begin
            chk <= chk ^ payload[7:0];
            if (is_alu) begin
              state     <= B1;
              wr_data_q <= payload[15:8];
            end else begin
              state     <= CHK;
              wr_data_q <= chk ^ payload[7:0];
            end
          end
          B1: begin
            chk       <= chk ^ payload[15:8];
            state     <= CHK;
            wr_data_q <= chk ^ payload[15:8];
          end
          default: begin
            state     <= IDLE;
            wr_data_q <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_resp_framer.sv
// Scoreboard bench for resp_framer: expected bytes are queued at stimulus time
// and popped by a monitor on every FIFO write.
module tb_resp_framer;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_VALID = 1'b0;
  logic [7:0]  Rd_DATA = 8'h00;
  logic        Rd_Valid = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        READY;
  logic        OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  resp_framer #(.FRAME_EN(1'b1), .ALU_WIDTH(16)) dut (
    .CLK(CLK), .RST_n(RST_n), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .Rd_DATA(Rd_DATA), .Rd_Valid(Rd_Valid), .FIFO_FULL(FIFO_FULL),
    .WR_DATA(WR_DATA), .WR_INC(WR_INC), .READY(READY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference framing: header, payload, XOR of payload only.
  task automatic push_alu(input logic [15:0] v);
    exp_q.push_back(8'h5A);
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0] ^ v[15:8]);
  endtask

  task automatic push_rd(input logic [7:0] v);
    exp_q.push_back(8'hA5);
    exp_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic pulse(input logic alu_v, input logic [15:0] alu, input logic rd_v, input logic [7:0] rd);
    OUT_VALID = alu_v;
    ALU_OUT   = alu;
    Rd_Valid  = rd_v;
    Rd_DATA   = rd;
    @(posedge CLK); #1;
    OUT_VALID = 1'b0;
    Rd_Valid  = 1'b0;
  endtask

  task automatic expect_stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check(tag, {15'd0, WR_INC}, 16'd1);
    end
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || READY !== 1'b1) && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    check(tag, {15'd0, cyc < 100}, 16'd1);
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RST_n === 1'b1 && WR_INC === 1'b1) begin
      check("write_while_full", {15'd0, FIFO_FULL}, 16'd0);
      check("byte_expected", {15'd0, exp_q.size() != 0}, 16'd1);
      if (exp_q.size() != 0)
        check("wr_data", {8'd0, WR_DATA}, {8'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_wr_inc", {15'd0, WR_INC}, 16'd0);
    check("rst_wr_data", {8'd0, WR_DATA}, 16'h0000);
    check("rst_overrun", {15'd0, OVERRUN}, 16'd0);
    @(posedge CLK); #1;
    RST_n = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", {15'd0, READY}, 16'd1);

    // Plain ALU frame, first byte the cycle after the pulse
    @(posedge CLK); #1;
    push_alu(16'h1234);
    pulse(1'b1, 16'h1234, 1'b0, 8'h00);
    expect_stream("alu_stream", 4);
    wait_drain("alu_drain");

    // READ frame, READY back right after the third byte
    @(posedge CLK); #1;
    push_rd(8'h3C);
    pulse(1'b0, 16'h0000, 1'b1, 8'h3C);
    expect_stream("rd_stream", 3);
    @(negedge CLK);
    check("rd_ready_after", {15'd0, READY}, 16'd1);
    check("rd_idle_after", {15'd0, WR_INC}, 16'd0);

    // Simultaneous ALU + READ: back-to-back frames, no overrun
    @(posedge CLK); #1;
    push_alu(16'h00FF);
    push_rd(8'h81);
    pulse(1'b1, 16'h00FF, 1'b1, 8'h81);
    check("dual_ready_low", {15'd0, READY}, 16'd0);
    expect_stream("dual_stream", 7);
    wait_drain("dual_drain");
    check("dual_no_overrun", {15'd0, OVERRUN}, 16'd0);

    // FIFO full stall after payload byte 34
    @(posedge CLK); #1;
    push_alu(16'h1234);
    pulse(1'b1, 16'h1234, 1'b0, 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK); #1;
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_wr_inc", {15'd0, WR_INC}, 16'd0);
      check("stall_wr_data", {8'd0, WR_DATA}, 16'h0012);
    end
    @(posedge CLK); #1;
    FIFO_FULL = 1'b0;
    expect_stream("stall_resume", 2);
    wait_drain("stall_drain");

    // Second request mid-frame is dropped and flagged
    @(posedge CLK); #1;
    push_alu(16'h1234);
    pulse(1'b1, 16'h1234, 1'b0, 8'h00);
    @(negedge CLK);
    @(posedge CLK); #1;
    pulse(1'b1, 16'hBEEF, 1'b0, 8'h00);
    check("overrun_set", {15'd0, OVERRUN}, 16'd1);
    wait_drain("overrun_drain");
    repeat (3) @(negedge CLK);
    check("overrun_sticky", {15'd0, OVERRUN}, 16'd1);

    // Reset during B0 aborts at once
    @(posedge CLK); #1;
    push_alu(16'h1234);
    pulse(1'b1, 16'h1234, 1'b0, 8'h00);
    @(negedge CLK);
    @(posedge CLK); #1;
    RST_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_wr_inc", {15'd0, WR_INC}, 16'd0);
    check("abort_wr_data", {8'd0, WR_DATA}, 16'h0000);
    check("abort_overrun", {15'd0, OVERRUN}, 16'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_n = 1'b1;
    @(negedge CLK);
    check("abort_ready", {15'd0, READY}, 16'd1);
    check("abort_idle", {15'd0, WR_INC}, 16'd0);
    @(posedge CLK); #1;
    push_rd(8'h07);
    pulse(1'b0, 16'h0000, 1'b1, 8'h07);
    expect_stream("post_reset_stream", 3);
    wait_drain("post_reset_drain");

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
